// File: rtl/vx_cluster_ctrl_pkg.sv
// Shared types and DCR address decode for the cluster controller.
// Request fields use maximum widths; instances slice what they need.
package vx_cluster_ctrl_pkg;

    localparam int MAX_SOCKETS = 32;
    localparam int MAX_ADDR_W  = 32;
    localparam int MAX_DATA_W  = 64;

    typedef struct packed {
        logic [MAX_SOCKETS-1:0] mask;
        logic [MAX_ADDR_W-1:0]  addr;
        logic [MAX_DATA_W-1:0]  data;
    } dcr_req_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } drain_state_e;

    // Broadcast window wins over the unicast window when they overlap.
    function automatic logic [MAX_SOCKETS-1:0] dcr_decode(
        input logic [MAX_ADDR_W-1:0]  addr,
        input logic [MAX_SOCKETS-1:0] sock_en,
        input logic [MAX_ADDR_W-1:0]  bcast_begin,
        input logic [MAX_ADDR_W-1:0]  bcast_end,
        input logic [MAX_ADDR_W-1:0]  ucast_base,
        input int unsigned            num_sockets
    );
        logic [MAX_ADDR_W-1:0] ofs;
        ofs = addr - ucast_base;
        if (addr >= bcast_begin && addr < bcast_end) begin
            return sock_en;
        end
        if (addr >= ucast_base && ofs < num_sockets) begin
            return (MAX_SOCKETS'(1) << ofs) & sock_en;
        end
        return '0;
    endfunction

endpackage

// File: rtl/vx_cluster_ctrl_busy_filter.sv
// Idle-hysteresis filter: busy stays high until BUSY_HOLD consecutive idle cycles.
module vx_cluster_ctrl_busy_filter #(
    parameter int unsigned BUSY_HOLD = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic busy_o
);

    localparam int unsigned CNT_W = $clog2(BUSY_HOLD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        cnt_d = cnt_q;
        if (raw_i) begin
            cnt_d = CNT_W'(BUSY_HOLD);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/vx_cluster_ctrl.sv
// Cluster control: DCR fan-out pipeline, filtered busy aggregation, drain handshake.
// Optional perf counters are built when VX_CLUSTER_CTRL_PERF_EN is defined.
module vx_cluster_ctrl
    import vx_cluster_ctrl_pkg::*;
#(
    parameter int unsigned           NUM_SOCKETS = 4,
    parameter int unsigned           DCR_ADDR_W  = 12,
    parameter int unsigned           DCR_DATA_W  = 32,
    parameter logic [DCR_ADDR_W-1:0] BCAST_BEGIN = 'h001,
    parameter logic [DCR_ADDR_W-1:0] BCAST_END   = 'h020,
    parameter logic [DCR_ADDR_W-1:0] UCAST_BASE  = 'h100,
    parameter int unsigned           DCR_PIPE    = 1,
    parameter int unsigned           BUSY_HOLD   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   dcr_wr_valid_i,
    output logic                   dcr_wr_ready_o,
    input  logic [DCR_ADDR_W-1:0]  dcr_wr_addr_i,
    input  logic [DCR_DATA_W-1:0]  dcr_wr_data_i,
    output logic [NUM_SOCKETS-1:0] sock_dcr_wr_valid_o,
    output logic [DCR_ADDR_W-1:0]  sock_dcr_wr_addr_o,
    output logic [DCR_DATA_W-1:0]  sock_dcr_wr_data_o,
    input  logic [NUM_SOCKETS-1:0] sock_en_i,
    input  logic [NUM_SOCKETS-1:0] sock_busy_i,
    input  logic                   drain_req_i,
    output logic                   drain_ack_o,
`ifdef VX_CLUSTER_CTRL_PERF_EN
    output logic [63:0]            perf_busy_cycles_o,
    output logic [31:0]            perf_dcr_drops_o,
`endif
    output logic                   busy_o
);

    drain_state_e           state_q, state_d;
    logic                   init_q;
    logic                   accept;
    logic                   pipe_busy;
    logic                   raw_busy;
    logic [MAX_SOCKETS-1:0] dec_mask;
    dcr_req_t               req_in, req_out;
    logic                   unused_req;

    assign accept   = dcr_wr_valid_i & dcr_wr_ready_o;
    assign dec_mask = dcr_decode(MAX_ADDR_W'(dcr_wr_addr_i), MAX_SOCKETS'(sock_en_i),
                                 MAX_ADDR_W'(BCAST_BEGIN), MAX_ADDR_W'(BCAST_END),
                                 MAX_ADDR_W'(UCAST_BASE), NUM_SOCKETS);

    always_comb begin
        req_in      = '0;
        req_in.mask = accept ? dec_mask : '0;
        req_in.addr = MAX_ADDR_W'(dcr_wr_addr_i);
        req_in.data = MAX_DATA_W'(dcr_wr_data_i);
    end

    if (DCR_PIPE == 0) begin : g_comb
        assign req_out   = req_in;
        assign pipe_busy = 1'b0;
    end else begin : g_pipe
        dcr_req_t            stage_q [DCR_PIPE];
        logic [DCR_PIPE-1:0] stage_vld;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(DCR_PIPE); i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= req_in;
                for (int i = 1; i < int'(DCR_PIPE); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        for (genvar g = 0; g < int'(DCR_PIPE); g++) begin : g_vld
            assign stage_vld[g] = |stage_q[g].mask;
        end

        assign req_out   = stage_q[DCR_PIPE-1];
        assign pipe_busy = |stage_vld;
    end

    assign sock_dcr_wr_valid_o = req_out.mask[NUM_SOCKETS-1:0];
    assign sock_dcr_wr_addr_o  = req_out.addr[DCR_ADDR_W-1:0];
    assign sock_dcr_wr_data_o  = req_out.data[DCR_DATA_W-1:0];
    assign unused_req          = ^req_out;

    assign raw_busy = (|(sock_busy_i & sock_en_i)) | pipe_busy;

    vx_cluster_ctrl_busy_filter #(
        .BUSY_HOLD (BUSY_HOLD)
    ) u_busy_filter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .raw_i  (raw_busy),
        .busy_o (busy_o)
    );

    // init_q keeps ready low until the first clock after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        dcr_wr_ready_o = 1'b0;
        drain_ack_o    = 1'b0;
        case (state_q)
            IDLE: begin
                dcr_wr_ready_o = init_q;
                if (drain_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!drain_req_i) begin
                    state_d = IDLE;
                end else if (!pipe_busy && !busy_o) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                drain_ack_o = 1'b1;
                if (!drain_req_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef VX_CLUSTER_CTRL_PERF_EN
    logic [63:0] perf_busy_q;
    logic [31:0] perf_drop_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_busy_q <= '0;
            perf_drop_q <= '0;
        end else begin
            if (busy_o) perf_busy_q <= perf_busy_q + 64'd1;
            if (accept && dec_mask == '0 && perf_drop_q != '1) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles_o = perf_busy_q;
    assign perf_dcr_drops_o   = perf_drop_q;
`endif

endmodule

// File: tb/tb_vx_cluster_ctrl.sv
// Self-checking bench for vx_cluster_ctrl: DCR fan-out scoreboard, busy hysteresis,
// drain handshake, abort and async reset.
module tb_vx_cluster_ctrl;

    localparam int NS     = 4;
    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int P_PIPE = 1;
    localparam int HOLD   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dcr_valid = 1'b0;
    logic          dcr_ready;
    logic [AW-1:0] dcr_addr = '0;
    logic [DW-1:0] dcr_data = '0;
    logic [NS-1:0] sock_valid;
    logic [AW-1:0] sock_addr;
    logic [DW-1:0] sock_data;
    logic [NS-1:0] sock_en = '0;
    logic [NS-1:0] sock_busy = '0;
    logic          drain_req = 1'b0;
    logic          drain_ack;
    logic          busy;
`ifdef VX_CLUSTER_CTRL_PERF_EN
    logic [63:0]   perf_busy_cycles;
    logic [31:0]   perf_dcr_drops;
`endif

    vx_cluster_ctrl #(
        .NUM_SOCKETS (NS),
        .DCR_ADDR_W  (AW),
        .DCR_DATA_W  (DW),
        .BCAST_BEGIN (12'h001),
        .BCAST_END   (12'h020),
        .UCAST_BASE  (12'h100),
        .DCR_PIPE    (P_PIPE),
        .BUSY_HOLD   (HOLD)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .dcr_wr_valid_i      (dcr_valid),
        .dcr_wr_ready_o      (dcr_ready),
        .dcr_wr_addr_i       (dcr_addr),
        .dcr_wr_data_i       (dcr_data),
        .sock_dcr_wr_valid_o (sock_valid),
        .sock_dcr_wr_addr_o  (sock_addr),
        .sock_dcr_wr_data_o  (sock_data),
        .sock_en_i           (sock_en),
        .sock_busy_i         (sock_busy),
        .drain_req_i         (drain_req),
        .drain_ack_o         (drain_ack),
`ifdef VX_CLUSTER_CTRL_PERF_EN
        .perf_busy_cycles_o  (perf_busy_cycles),
        .perf_dcr_drops_o    (perf_dcr_drops),
`endif
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        logic [NS-1:0] mask;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_en = 1'b0;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dcr_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NS-1:0] m);
        exp_t e;
        dcr_valid = 1'b1;
        dcr_addr  = a;
        dcr_data  = d;
        if (m != '0) begin
            e.due  = cyc + P_PIPE;
            e.mask = m;
            e.addr = a;
            e.data = d;
            sb_q.push_back(e);
        end
        tick();
        dcr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sock_valid", 64'(sock_valid), 64'(e.mask));
                check_eq("sock_addr", 64'(sock_addr), 64'(e.addr));
                check_eq("sock_data", 64'(sock_data), 64'(e.data));
            end else begin
                check_eq("sock_idle", 64'(sock_valid), 64'(0));
                if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                    check_eq("sb_late", 64'(cyc), 64'(sb_q[0].due));
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [NS-1:0] en;
        logic [NS-1:0] mask;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{addr: 12'h102, en: 4'b1111, mask: 4'b0100});
        vecs.push_back('{addr: 12'h102, en: 4'b1011, mask: 4'b0000});
        vecs.push_back('{addr: 12'h050, en: 4'b1011, mask: 4'b0000});
        vecs.push_back('{addr: 12'h020, en: 4'b1011, mask: 4'b0000});
        vecs.push_back('{addr: 12'h001, en: 4'b1011, mask: 4'b1011});
        vecs.push_back('{addr: 12'h01F, en: 4'b0110, mask: 4'b0110});
        vecs.push_back('{addr: 12'h103, en: 4'b1011, mask: 4'b1000});
        vecs.push_back('{addr: 12'h104, en: 4'b1111, mask: 4'b0000});
        vecs.push_back('{addr: 12'h100, en: 4'b1111, mask: 4'b0001});

        // reset state
        #2;
        check_eq("rst_valid", 64'(sock_valid), 64'(0));
        check_eq("rst_addr", 64'(sock_addr), 64'(0));
        check_eq("rst_data", 64'(sock_data), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_ack", 64'(drain_ack), 64'(0));
        check_eq("rst_ready", 64'(dcr_ready), 64'(0));
`ifdef VX_CLUSTER_CTRL_PERF_EN
        check_eq("rst_perf_drops", 64'(perf_dcr_drops), 64'(0));
        check_eq("rst_perf_busy", perf_busy_cycles, 64'(0));
`endif
        @(negedge clk);
        #1 rst_n = 1'b1;
        check_eq("ready_before_clk", 64'(dcr_ready), 64'(0));
        tick();
        check_eq("ready_after_clk", 64'(dcr_ready), 64'(1));
        mon_en = 1'b1;

        // broadcast
        sock_en = 4'b1011;
        dcr_write(12'h005, 32'hDEAD, 4'b1011);
        tick();

        // unicast, drops and window edges, back to back
        foreach (vecs[i]) begin
            sock_en = vecs[i].en;
            dcr_write(vecs[i].addr, $urandom, vecs[i].mask);
        end
        sock_en = 4'b1011;
        tick(8);
`ifdef VX_CLUSTER_CTRL_PERF_EN
        check_eq("perf_drops", 64'(perf_dcr_drops), 64'(4));
`endif
        check_eq("busy_settled", 64'(busy), 64'(0));

        // disabled socket busy is ignored
        sock_busy = 4'b0100;
        tick();
        sock_busy = '0;
        for (int k = 0; k < 3; k++) begin
            check_eq("busy_masked", 64'(busy), 64'(0));
            tick();
        end

        // single-cycle pulse
        sock_busy = 4'b0001;
        tick();
        sock_busy = '0;
        for (int k = 1; k <= 6; k++) begin
            check_eq("hyst_pulse", 64'(busy), 64'(k <= HOLD));
            tick();
        end

        // re-pulse while hold count is 2 reloads it
        sock_busy = 4'b0001;
        tick();
        sock_busy = '0;
        tick(2);
        check_eq("hyst_mid", 64'(busy), 64'(1));
        sock_busy = 4'b0001;
        tick();
        sock_busy = '0;
        for (int k = 4; k <= 9; k++) begin
            check_eq("hyst_reload", 64'(busy), 64'(k <= 7));
            tick();
        end

        // drain with busy socket
        sock_busy = 4'b0001;
        drain_req = 1'b1;
        tick();
        check_eq("drain_ready", 64'(dcr_ready), 64'(0));
        check_eq("drain_busy", 64'(busy), 64'(1));
        dcr_write(12'h005, 32'hBAD0, 4'b0000);
        tick(3);
        check_eq("drain_no_ack", 64'(drain_ack), 64'(0));
        sock_busy = '0;
        for (int k = 0; k <= 6; k++) begin
            check_eq("drain_ack_time", 64'(drain_ack), 64'(k >= HOLD + 1));
            tick();
        end
        check_eq("done_ready", 64'(dcr_ready), 64'(0));
        sock_busy = 4'b0001;
        tick();
        sock_busy = '0;
        check_eq("done_rebusy", 64'(busy), 64'(1));
        check_eq("done_hold", 64'(drain_ack), 64'(1));
        drain_req = 1'b0;
        tick();
        check_eq("release_ack", 64'(drain_ack), 64'(0));
        check_eq("release_ready", 64'(dcr_ready), 64'(1));
        tick(8);

        // drain request together with a write, then abort
        sock_en = 4'b1011;
        drain_req = 1'b1;
        dcr_write(12'h003, 32'hCAFE, 4'b1011);
        check_eq("abort_in_drain", 64'(dcr_ready), 64'(0));
        drain_req = 1'b0;
        tick();
        check_eq("abort_ready", 64'(dcr_ready), 64'(1));
        for (int k = 0; k < 5; k++) begin
            check_eq("abort_no_ack", 64'(drain_ack), 64'(0));
            tick();
        end
        tick(4);

        // async reset while a write is in flight
        sock_en = 4'b1111;
        dcr_write(12'h001, 32'h5555, 4'b0000);
        check_eq("pre_rst_valid", 64'(sock_valid), 64'(4'b1111));
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(sock_valid), 64'(0));
        check_eq("arst_addr", 64'(sock_addr), 64'(0));
        check_eq("arst_data", 64'(sock_data), 64'(0));
        check_eq("arst_busy", 64'(busy), 64'(0));
        check_eq("arst_ready", 64'(dcr_ready), 64'(0));
        check_eq("arst_ack", 64'(drain_ack), 64'(0));
        tick(2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check_eq("rerst_ready_low", 64'(dcr_ready), 64'(0));
        tick();
        check_eq("rerst_ready_high", 64'(dcr_ready), 64'(1));
        tick(5);
        check_eq("rerst_busy", 64'(busy), 64'(0));

        check_eq("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
